// File: rtl/intr_ctrl.sv
// Four-source interrupt controller: rising-edge capture into PENDING, maskable
// fixed-priority arbitration (bit 0 highest), and a REQ/SERVICE handshake with the control unit.
module intr_ctrl (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] IRQ_IN,
  input  logic       I_EN,
  input  logic       INTR_ACK,
  input  logic       SVC_DONE,
  input  logic       MASK_WE,
  input  logic [3:0] MASK_DIN,
  output logic       INTR,
  output logic [1:0] INTR_ID,
  output logic [3:0] PENDING,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [3:0] prev_r;
  logic [3:0] pending_r, pending_nxt_s;
  logic [3:0] mask_r;
  logic [1:0] intr_id_r, intr_id_nxt_s;
  logic       intr_r, busy_r;
  logic [3:0] edge_s;
  logic [3:0] active_s;
  logic [3:0] clr_s;

  // Lowest set index of a 4-bit vector; bit 0 wins.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign edge_s   = IRQ_IN & ~prev_r;
  assign active_s = pending_r & mask_r;

  // Next-state, pending update and request-ID capture.
  always_comb begin
    state_nxt_s   = state_r;
    intr_id_nxt_s = intr_id_r;
    clr_s         = 4'b0000;
    case (state_r)
      ST_IDLE: begin
        if (I_EN && (active_s != 4'b0000)) begin
          state_nxt_s   = ST_REQ;
          intr_id_nxt_s = lowest_idx(active_s);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (INTR_ACK) begin
          state_nxt_s = ST_SERVICE;
          clr_s       = onehot4(intr_id_r);
        end else if (!I_EN) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (SVC_DONE) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SERVICE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // A new edge on the bit being acknowledged keeps it pending.
    pending_nxt_s = (pending_r & ~clr_s) | edge_s;
  end

  // State, capture registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      prev_r    <= IRQ_IN;
      pending_r <= 4'b0000;
      mask_r    <= 4'b0000;
      intr_id_r <= 2'd0;
      intr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      prev_r    <= IRQ_IN;
      pending_r <= pending_nxt_s;
      mask_r    <= MASK_WE ? MASK_DIN : mask_r;
      intr_id_r <= intr_id_nxt_s;
      intr_r    <= (state_nxt_s == ST_REQ);
      busy_r    <= (state_nxt_s == ST_SERVICE);
    end
  end

  assign INTR    = intr_r;
  assign INTR_ID = intr_id_r;
  assign PENDING = pending_r;
  assign BUSY    = busy_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: each step queues the outputs expected after
// the next clock edge, then pops and compares them once the edge has passed.
module tb_intr_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] IRQ_IN;
  logic       I_EN;
  logic       INTR_ACK;
  logic       SVC_DONE;
  logic       MASK_WE;
  logic [3:0] MASK_DIN;
  logic       INTR;
  logic [1:0] INTR_ID;
  logic [3:0] PENDING;
  logic       BUSY;

  typedef struct {
    string      tag;
    logic       intr;
    logic [1:0] id;
    logic [3:0] pend;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  intr_ctrl dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IRQ_IN   (IRQ_IN),
    .I_EN     (I_EN),
    .INTR_ACK (INTR_ACK),
    .SVC_DONE (SVC_DONE),
    .MASK_WE  (MASK_WE),
    .MASK_DIN (MASK_DIN),
    .INTR     (INTR),
    .INTR_ID  (INTR_ID),
    .PENDING  (PENDING),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, clock, then check.
  task automatic step(input string tag, input logic rst, input logic [3:0] irq,
                      input logic ien, input logic ack, input logic done,
                      input logic mwe, input logic [3:0] mdin,
                      input logic e_intr, input logic [1:0] e_id,
                      input logic [3:0] e_pend, input logic e_busy);
    exp_t e;
    RESET    = rst;
    IRQ_IN   = irq;
    I_EN     = ien;
    INTR_ACK = ack;
    SVC_DONE = done;
    MASK_WE  = mwe;
    MASK_DIN = mdin;
    e.tag  = tag;
    e.intr = e_intr;
    e.id   = e_id;
    e.pend = e_pend;
    e.busy = e_busy;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 8'd0, 8'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_intr"}, {7'd0, INTR},    {7'd0, e.intr});
      chk({e.tag, "_id"},   {6'd0, INTR_ID}, {6'd0, e.id});
      chk({e.tag, "_pend"}, {4'd0, PENDING}, {4'd0, e.pend});
      chk({e.tag, "_busy"}, {7'd0, BUSY},    {7'd0, e.busy});
    end
  endtask

  initial begin
    //    tag           rst irq     ien ack dn  mwe mdin      intr id    pend    busy
    step("rst0",        1, 4'b0000, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0000, 0);
    step("rst1",        1, 4'b0000, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0000, 0);
    // single source on bit 2
    step("s1_mask",     0, 4'b0000, 1, 0, 0, 1, 4'b1111,   0, 2'd0, 4'b0000, 0);
    step("s1_rise",     0, 4'b0100, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0100, 0);
    step("s1_req",      0, 4'b0100, 1, 0, 0, 0, 4'b0000,   1, 2'd2, 4'b0100, 0);
    step("s1_ack",      0, 4'b0100, 1, 1, 0, 0, 4'b0000,   0, 2'd2, 4'b0000, 1);
    step("s1_svc",      0, 4'b0100, 1, 1, 0, 0, 4'b0000,   0, 2'd2, 4'b0000, 1);
    step("s1_done",     0, 4'b0100, 1, 0, 1, 0, 4'b0000,   0, 2'd2, 4'b0000, 0);
    step("s1_fall",     0, 4'b0000, 1, 0, 1, 0, 4'b0000,   0, 2'd2, 4'b0000, 0);
    // two simultaneous sources, priority order
    step("s2_rise",     0, 4'b1010, 1, 0, 0, 0, 4'b0000,   0, 2'd2, 4'b1010, 0);
    step("s2_req1",     0, 4'b1010, 1, 0, 0, 0, 4'b0000,   1, 2'd1, 4'b1010, 0);
    step("s2_ack1",     0, 4'b1010, 1, 1, 0, 0, 4'b0000,   0, 2'd1, 4'b1000, 1);
    step("s2_done1",    0, 4'b1010, 1, 0, 1, 0, 4'b0000,   0, 2'd1, 4'b1000, 0);
    step("s2_req2",     0, 4'b1010, 1, 0, 0, 0, 4'b0000,   1, 2'd3, 4'b1000, 0);
    step("s2_ack2",     0, 4'b1010, 1, 1, 0, 0, 4'b0000,   0, 2'd3, 4'b0000, 1);
    step("s2_done2",    0, 4'b1010, 1, 0, 1, 0, 4'b0000,   0, 2'd3, 4'b0000, 0);
    step("s2_fall",     0, 4'b0000, 1, 0, 0, 0, 4'b0000,   0, 2'd3, 4'b0000, 0);
    // masked source, then unmask
    step("s3_mask0",    0, 4'b0000, 1, 0, 0, 1, 4'b0000,   0, 2'd3, 4'b0000, 0);
    step("s3_rise",     0, 4'b0001, 1, 0, 0, 0, 4'b0000,   0, 2'd3, 4'b0001, 0);
    step("s3_masked",   0, 4'b0001, 1, 0, 0, 0, 4'b0000,   0, 2'd3, 4'b0001, 0);
    step("s3_mwe",      0, 4'b0001, 1, 0, 0, 1, 4'b0001,   0, 2'd3, 4'b0001, 0);
    step("s3_req",      0, 4'b0001, 1, 0, 0, 0, 4'b0000,   1, 2'd0, 4'b0001, 0);
    step("s3_ack",      0, 4'b0001, 1, 1, 0, 0, 4'b0000,   0, 2'd0, 4'b0000, 1);
    step("s3_done",     0, 4'b0001, 1, 0, 1, 0, 4'b0000,   0, 2'd0, 4'b0000, 0);
    step("s3_fall",     0, 4'b0000, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0000, 0);
    // withdrawn request and reissue; frozen request in flight
    step("s4_rise",     0, 4'b0001, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0001, 0);
    step("s4_req",      0, 4'b0001, 1, 0, 0, 0, 4'b0000,   1, 2'd0, 4'b0001, 0);
    step("s4_wd",       0, 4'b0001, 0, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0001, 0);
    step("s4_idle",     0, 4'b0001, 0, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0001, 0);
    step("s4_reissue",  0, 4'b0001, 1, 0, 0, 0, 4'b0000,   1, 2'd0, 4'b0001, 0);
    step("s4_frz",      0, 4'b0011, 1, 0, 0, 1, 4'b0000,   1, 2'd0, 4'b0011, 0);
    // ack collides with a new edge on the same bit
    step("s5_fall",     0, 4'b0010, 1, 0, 0, 0, 4'b0000,   1, 2'd0, 4'b0011, 0);
    step("s5_ackset",   0, 4'b0011, 1, 1, 0, 0, 4'b0000,   0, 2'd0, 4'b0011, 1);
    step("s5_done",     0, 4'b0011, 1, 0, 1, 0, 4'b0000,   0, 2'd0, 4'b0011, 0);
    step("s5_masked",   0, 4'b0011, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0011, 0);
    step("s5_mwe",      0, 4'b0011, 1, 0, 0, 1, 4'b0010,   0, 2'd0, 4'b0011, 0);
    step("s5_req",      0, 4'b0011, 1, 0, 0, 0, 4'b0000,   1, 2'd1, 4'b0011, 0);
    step("s5_ack",      0, 4'b0011, 1, 1, 0, 0, 4'b0000,   0, 2'd1, 4'b0001, 1);
    // reset mid-service with all sources held high
    step("s6_rise",     0, 4'b1111, 1, 0, 0, 0, 4'b0000,   0, 2'd1, 4'b1101, 1);
    step("s6_rst",      1, 4'b1111, 1, 1, 1, 0, 4'b0000,   0, 2'd0, 4'b0000, 0);
    step("s6_rel",      0, 4'b1111, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0000, 0);
    step("s6_hold",     0, 4'b1111, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0000, 0);
    step("s6_fall",     0, 4'b0000, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b0000, 0);
    step("s6_rerise",   0, 4'b1111, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b1111, 0);
    step("s6_nomask",   0, 4'b1111, 1, 0, 0, 0, 4'b0000,   0, 2'd0, 4'b1111, 0);
    if (sb_q.size() != 0) begin
      chk("sb_leftover", 8'(sb_q.size()), 8'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
